// File: rtl/pong_pkg.sv
// Shared screen, paddle and ball geometry plus the update-sequencer types
// used by the game controller, the renderer and the VGA timing generator.
package pong_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] score_t;

    localparam coord_t H_ACTIVE    = 10'd640;
    localparam coord_t V_ACTIVE    = 10'd480;
    localparam coord_t PADDLE_H    = 10'd64;
    localparam coord_t PADDLE_W    = 10'd8;
    localparam coord_t PADDLE1_X   = 10'd16;
    localparam coord_t PADDLE2_X   = 10'd616;
    localparam coord_t BALL_SIZE   = 10'd8;
    localparam coord_t PADDLE_STEP = 10'd4;
    localparam coord_t BALL_STEP   = 10'd2;

    localparam coord_t PADDLE_Y_MAX = V_ACTIVE - PADDLE_H;
    localparam coord_t BALL_X_MAX   = H_ACTIVE - BALL_SIZE;
    localparam coord_t BALL_Y_MAX   = V_ACTIVE - BALL_SIZE;
    localparam coord_t PADDLE_Y0    = PADDLE_Y_MAX >> 1;
    localparam coord_t BALL_X0      = BALL_X_MAX >> 1;
    localparam coord_t BALL_Y0      = BALL_Y_MAX >> 1;

    localparam logic [5:0] SERVE_FRAMES = 6'd60;
    localparam score_t     SCORE_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PADDLE,
        ST_BALL,
        ST_RESOLVE
    } upd_state_e;

    typedef enum logic [1:0] {
        PH_SERVE,
        PH_PLAY,
        PH_OVER
    } phase_e;

    typedef struct packed {
        upd_state_e upd;
        phase_e     phase;
        logic       vx;         // 1 = moving right (+x)
        logic       vy;         // 1 = moving down (+y)
        logic [5:0] serve_cnt;
    } dbg_t;

    // One ball axis step, clamped to [0, lim].
    function automatic coord_t ball_step(coord_t v, logic inc, coord_t lim);
        if (inc) return (v + BALL_STEP > lim) ? lim : v + BALL_STEP;
        return (v < BALL_STEP) ? '0 : v - BALL_STEP;
    endfunction

    function automatic score_t sat_inc(score_t s);
        return (s >= SCORE_MAX) ? SCORE_MAX : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Frame-update bundle between the frame source / renderer side (master)
// and the game controller (slave).
interface pong_game_ctrl_if;
    // frame_tick is a one-cycle request taken only while the controller is
    // idle (busy = 0); a tick seen while busy is dropped. busy covers the
    // three update cycles and frame_done pulses once when results are final.
    logic                  frame_tick;
    logic [3:0]            btns;
    pong_pkg::coord_t      p1_y;
    pong_pkg::coord_t      p2_y;
    pong_pkg::coord_t      ball_x;
    pong_pkg::coord_t      ball_y;
    pong_pkg::score_t      score1;
    pong_pkg::score_t      score2;
    logic                  game_over;
    logic                  busy;
    logic                  frame_done;
    pong_pkg::dbg_t        dbg;

    modport master (
        output frame_tick, btns,
        input  p1_y, p2_y, ball_x, ball_y, score1, score2,
        input  game_over, busy, frame_done, dbg
    );

    modport slave (
        input  frame_tick, btns,
        output p1_y, p2_y, ball_x, ball_y, score1, score2,
        output game_over, busy, frame_done, dbg
    );
endinterface

// File: rtl/pong_paddle_step.sv
// Combinational paddle move: one clamped step up or down, no move when
// both or neither button is pressed.
module pong_paddle_step
    import pong_pkg::*;
(
    input  coord_t y,
    input  logic   up,
    input  logic   down,
    output coord_t y_next
);
    logic [10:0] up_v;
    logic [10:0] dn_v;

    always_comb begin
        up_v   = {1'b0, y} - {1'b0, PADDLE_STEP};
        dn_v   = {1'b0, y} + {1'b0, PADDLE_STEP};
        y_next = y;
        // Borrow out of the 11-bit subtract means the step would pass row 0.
        if (up && !down) begin
            y_next = up_v[10] ? '0 : up_v[9:0];
        end else if (down && !up) begin
            y_next = (dn_v > {1'b0, PADDLE_Y_MAX}) ? PADDLE_Y_MAX : dn_v[9:0];
        end
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// Per-frame game sequencer: on each accepted frame tick it steps paddles,
// moves the ball, then resolves walls, paddle hits, misses and scoring.
module pong_game_ctrl
    import pong_pkg::*;
(
    input  logic            CLK,
    input  logic            rst_n,
    pong_game_ctrl_if.slave bus
);
    upd_state_e state, state_n;
    phase_e     phase;
    coord_t     p1_y, p2_y, ball_x, ball_y, p1_next, p2_next;
    score_t     score1, score2, score1_inc, score2_inc;
    logic [5:0] serve_cnt;
    logic [3:0] btns_q;
    logic       vx, vy, game_over, frame_done, busy;
    logic       hit1, hit2, miss_l, miss_r, win, restart;

    pong_paddle_step u_p1 (.y(p1_y), .up(btns_q[3]), .down(btns_q[2]), .y_next(p1_next));
    pong_paddle_step u_p2 (.y(p2_y), .up(btns_q[1]), .down(btns_q[0]), .y_next(p2_next));

    assign hit1 = !vx && (ball_x <= PADDLE1_X + PADDLE_W) && (ball_x + BALL_SIZE > PADDLE1_X)
                  && (ball_y + BALL_SIZE > p1_y) && (ball_y < p1_y + PADDLE_H);
    assign hit2 = vx && (ball_x + BALL_SIZE >= PADDLE2_X) && (ball_x < PADDLE2_X + PADDLE_W)
                  && (ball_y + BALL_SIZE > p2_y) && (ball_y < p2_y + PADDLE_H);
    assign miss_l     = (ball_x == '0);
    assign miss_r     = (ball_x == BALL_X_MAX);
    assign score1_inc = sat_inc(score1);
    assign score2_inc = sat_inc(score2);
    assign win        = miss_l ? (score2_inc == SCORE_MAX) : (score1_inc == SCORE_MAX);
    assign restart    = btns_q[3] && btns_q[1];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        busy    = 1'b0;
        case (state)
            ST_IDLE:    if (bus.frame_tick) state_n = ST_PADDLE;
            ST_PADDLE:  begin busy = 1'b1; state_n = ST_BALL;    end
            ST_BALL:    begin busy = 1'b1; state_n = ST_RESOLVE; end
            ST_RESOLVE: begin busy = 1'b1; state_n = ST_IDLE;    end
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p1_y       <= PADDLE_Y0;
            p2_y       <= PADDLE_Y0;
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            vx         <= 1'b1;
            vy         <= 1'b1;
            score1     <= '0;
            score2     <= '0;
            game_over  <= 1'b0;
            frame_done <= 1'b0;
            phase      <= PH_SERVE;
            serve_cnt  <= SERVE_FRAMES;
            btns_q     <= '0;
        end else begin
            frame_done <= (state == ST_RESOLVE);
            case (state)
                ST_IDLE: if (bus.frame_tick) btns_q <= bus.btns;
                ST_PADDLE: begin
                    p1_y <= p1_next;
                    p2_y <= p2_next;
                end
                ST_BALL: begin
                    case (phase)
                        PH_PLAY: begin
                            ball_x <= ball_step(ball_x, vx, BALL_X_MAX);
                            ball_y <= ball_step(ball_y, vy, BALL_Y_MAX);
                        end
                        PH_SERVE: begin
                            // The frame that empties the counter is still a frozen one.
                            if (serve_cnt <= 6'd1) begin
                                serve_cnt <= '0;
                                phase     <= PH_PLAY;
                            end else begin
                                serve_cnt <= serve_cnt - 6'd1;
                            end
                        end
                        PH_OVER: if (restart) begin
                            score1    <= '0;
                            score2    <= '0;
                            game_over <= 1'b0;
                            ball_x    <= BALL_X0;
                            ball_y    <= BALL_Y0;
                            vx        <= 1'b1;
                            vy        <= 1'b1;
                            serve_cnt <= SERVE_FRAMES;
                            phase     <= PH_SERVE;
                        end
                        default: ;
                    endcase
                end
                ST_RESOLVE: if (phase == PH_PLAY) begin
                    if (ball_y == '0)             vy <= 1'b1;
                    else if (ball_y == BALL_Y_MAX) vy <= 1'b0;
                    if (hit1) begin
                        vx     <= 1'b1;
                        ball_x <= PADDLE1_X + PADDLE_W;
                    end else if (hit2) begin
                        vx     <= 1'b0;
                        ball_x <= PADDLE2_X - BALL_SIZE;
                    end else if (miss_l || miss_r) begin
                        // Serve heads toward whoever just conceded.
                        if (miss_l) score2 <= score2_inc;
                        else        score1 <= score1_inc;
                        vx        <= miss_r;
                        ball_x    <= BALL_X0;
                        ball_y    <= BALL_Y0;
                        serve_cnt <= SERVE_FRAMES;
                        phase     <= win ? PH_OVER : PH_SERVE;
                        game_over <= win;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.p1_y       = p1_y;
    assign bus.p2_y       = p2_y;
    assign bus.ball_x     = ball_x;
    assign bus.ball_y     = ball_y;
    assign bus.score1     = score1;
    assign bus.score2     = score2;
    assign bus.game_over  = game_over;
    assign bus.busy       = busy;
    assign bus.frame_done = frame_done;
    assign bus.dbg        = '{upd: state, phase: phase, vx: vx, vy: vy, serve_cnt: serve_cnt};
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: plays scripted rallies with known
// trajectories and checks positions, scores and phases at chosen frames.
module tb_pong_game_ctrl;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    pong_game_ctrl_if bus();

    pong_game_ctrl dut (.CLK(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ball(input int x, input int y);
        chk("ball_x", 32'(bus.ball_x), 32'(x));
        chk("ball_y", 32'(bus.ball_y), 32'(y));
    endtask

    task automatic chk_pad(input int p1, input int p2);
        chk("p1_y", 32'(bus.p1_y), 32'(p1));
        chk("p2_y", 32'(bus.p2_y), 32'(p2));
    endtask

    task automatic chk_score(input int s1, input int s2, input int go);
        chk("score1", 32'(bus.score1), 32'(s1));
        chk("score2", 32'(bus.score2), 32'(s2));
        chk("game_over", 32'(bus.game_over), 32'(go));
    endtask

    task automatic chk_dir(input int vx, input int vy);
        chk("vx", 32'(bus.dbg.vx), 32'(vx));
        chk("vy", 32'(bus.dbg.vy), 32'(vy));
    endtask

    task automatic chk_phase(input phase_e ph, input int cnt);
        chk("phase", 32'(bus.dbg.phase), 32'(ph));
        chk("serve_cnt", 32'(bus.dbg.serve_cnt), 32'(cnt));
    endtask

    // One frame: tick with buttons held, return at the frame_done cycle.
    task automatic frame(input logic [3:0] b);
        int n;
        @(negedge clk);
        bus.btns       = b;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            compared++;
            mismatched++;
            $error("FAIL frame_timeout: observed no frame_done, required pulse within 10 cycles");
        end
    endtask

    task automatic run(input int n, input logic [3:0] b);
        repeat (n) frame(b);
    endtask

    initial begin
        // Reset and reset values
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        bus.btns       = 4'b0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_pad(208, 208);
        chk_ball(316, 236);
        chk_score(0, 0, 0);
        chk_dir(1, 1);
        chk_phase(PH_SERVE, 60);
        chk("busy_rst", 32'(bus.busy), 32'd0);
        chk("done_rst", 32'(bus.frame_done), 32'd0);

        // Cycle timing, and a second tick at cycle 2 must be dropped
        @(negedge clk);
        bus.frame_tick = 1'b1;
        chk("busy_c0", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("busy_c1", 32'(bus.busy), 32'd1);
        chk("done_c1", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        bus.frame_tick = 1'b1;
        chk("busy_c2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        chk("busy_c3", 32'(bus.busy), 32'd1);
        chk("done_c3", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        chk("busy_c4", 32'(bus.busy), 32'd0);
        chk("done_c4", 32'(bus.frame_done), 32'd1);
        chk("cnt_c4", 32'(bus.dbg.serve_cnt), 32'd59);
        @(negedge clk);
        chk("done_c5", 32'(bus.frame_done), 32'd0);
        chk("busy_c5", 32'(bus.busy), 32'd0);

        // Reset in the middle of an update
        @(negedge clk);
        bus.btns       = 4'b1000;
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        @(negedge clk);
        chk("p1_mid", 32'(bus.p1_y), 32'd204);
        rst_n = 1'b0;
        #1;
        chk_pad(208, 208);
        chk_phase(PH_SERVE, 60);
        chk("busy_mid_rst", 32'(bus.busy), 32'd0);
        chk("upd_mid_rst", 32'(bus.dbg.upd), 32'(ST_IDLE));
        @(negedge clk);
        rst_n    = 1'b1;
        bus.btns = 4'b0000;

        // Serve countdown with paddle moves (p1 up to 0, p2 down to 416)
        run(1, 4'b1101);
        chk_pad(208, 212);
        run(29, 4'b1001);
        chk_ball(316, 236);
        chk_phase(PH_SERVE, 30);
        run(21, 4'b1001);
        chk_pad(8, 412);
        run(1, 4'b1001);
        chk_pad(4, 416);
        run(1, 4'b1001);
        chk_pad(0, 416);
        run(7, 4'b1001);
        chk_pad(0, 416);
        chk_ball(316, 236);
        chk_phase(PH_PLAY, 0);
        run(1, 4'b0000);
        chk_ball(318, 238);

        // Bottom wall, then right paddle hit
        run(117, 4'b0000);
        chk_ball(552, 472);
        chk_dir(1, 0);
        run(1, 4'b0000);
        chk_ball(554, 470);
        run(26, 4'b0000);
        chk_ball(606, 418);
        chk_dir(1, 0);
        run(1, 4'b0000);
        chk_ball(608, 416);
        chk_dir(0, 0);
        run(1, 4'b0000);
        chk_ball(606, 414);

        // Top wall on the way left
        run(206, 4'b0000);
        chk_ball(194, 2);
        chk_dir(0, 0);
        run(1, 4'b0000);
        chk_ball(192, 0);
        chk_dir(0, 1);
        run(1, 4'b0000);
        chk_ball(190, 2);

        // Left paddle hit with p1 moved to 168
        run(42, 4'b0100);
        chk_pad(168, 416);
        run(40, 4'b0000);
        chk_ball(26, 166);
        chk_dir(0, 1);
        run(1, 4'b0000);
        chk_ball(24, 168);
        chk_dir(1, 1);

        // p2 intercepts at 192, p1 parked at 0 and misses
        run(42, 4'b1010);
        run(14, 4'b0010);
        chk_pad(0, 192);
        chk_ball(136, 280);
        run(235, 4'b0000);
        chk_ball(606, 194);
        run(1, 4'b0000);
        chk_ball(608, 192);
        chk_dir(0, 0);
        run(95, 4'b0000);
        chk_ball(418, 2);
        run(1, 4'b0000);
        chk_ball(416, 0);
        run(207, 4'b0000);
        chk_ball(2, 414);
        run(1, 4'b0000);
        chk_ball(316, 236);
        chk_score(0, 1, 0);
        chk_dir(0, 1);
        chk_phase(PH_SERVE, 60);

        // p1 returns the serve, p2 misses
        run(4, 4'b0101);
        chk_pad(16, 208);
        run(56, 4'b0100);
        chk_pad(240, 208);
        chk_phase(PH_PLAY, 0);
        run(145, 4'b0100);
        chk_pad(416, 208);
        chk_ball(26, 418);
        run(1, 4'b0100);
        chk_ball(24, 416);
        chk_dir(1, 0);
        run(303, 4'b0000);
        chk_ball(630, 190);
        run(1, 4'b0000);
        chk_ball(316, 236);
        chk_score(1, 1, 0);
        chk_dir(1, 1);

        // Right misses up to the winning point
        run(218, 4'b0000);
        chk_score(2, 1, 0);
        chk_dir(1, 0);
        run(1308, 4'b0000);
        chk_score(8, 1, 0);
        chk_dir(1, 0);
        chk_phase(PH_SERVE, 60);
        run(218, 4'b0000);
        chk_score(9, 1, 1);
        chk_ball(316, 236);
        chk("phase_over", 32'(bus.dbg.phase), 32'(PH_OVER));

        // Game over: paddles move, ball frozen, restart on p1Up + p2Up
        run(1, 4'b1000);
        chk_pad(412, 208);
        chk_ball(316, 236);
        chk_score(9, 1, 1);
        run(1, 4'b1010);
        chk_pad(408, 204);
        chk_score(0, 0, 0);
        chk_ball(316, 236);
        chk_dir(1, 1);
        chk_phase(PH_SERVE, 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Per-frame game-logic sequencer for ShadyPong. Once per video frame, on a start-of-blanking tick from the VGA timing generator, it steps both paddles from the button inputs, advances the ball, and resolves wall bounces, paddle hits and misses. It also keeps score and runs the serve/game-over flow. Its position and score registers feed the pixel renderer and hold still for the whole active display period.

## Interface
- H_ACTIVE, 640: visible width (px)
- V_ACTIVE, 480: visible height (px)
- PADDLE_H, 64; PADDLE_W, 8: paddle size
- PADDLE1_X, 16; PADDLE2_X, 616: paddle left edges
- BALL_SIZE, 8: square ball edge
- PADDLE_STEP, 4; BALL_STEP, 2: px per frame
- SERVE_FRAMES, 60: frames ball is frozen before serve
- SCORE_MAX, 9: winning score

Ports:
- CLK  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- btns  in  4  {p1Up, p1Down, p2Up, p2Down}, already synchronised
- p1_y, p2_y  out  10  paddle top row
- ball_x, ball_y  out  10  ball top-left
- score1, score2  out  4  points
- game_over  out  1  a player reached SCORE_MAX
- busy  out  1  update in progress
- frame_done  out  1  one-cycle pulse when the update completes

## Operation
- Reset values:
  - p1_y = p2_y = 208.
  - ball = (316, 236); velocity +x, +y.
  - scores 0; game_over 0; busy 0; frame_done 0.
  - Phase SERVE, serve_cnt = SERVE_FRAMES.
- Update FSM: IDLE -> PADDLE -> BALL -> RESOLVE -> IDLE.
  - IDLE leaves only when frame_tick = 1.
  - frame_tick while not in IDLE is ignored, not queued.
- PADDLE:
  - Up only: y = max(y - PADDLE_STEP, 0).
  - Down only: y = min(y + PADDLE_STEP, V_ACTIVE - PADDLE_H).
  - Both or neither: no change.
  - Evaluated independently per player. Uses 11-bit intermediates so there is no wrap.
- BALL:
  - Phase PLAY: x ± BALL_STEP, y ± BALL_STEP by direction bits, clamped to [0, H_ACTIVE - BALL_SIZE] and [0, V_ACTIVE - BALL_SIZE].
  - Phase SERVE: ball frozen; serve_cnt decrements; at 0 the phase becomes PLAY.
  - Phase OVER: ball frozen.
- RESOLVE (PLAY only, priority order):
  1. Top wall: y == 0 -> vy = down. Bottom wall: y == V_ACTIVE - BALL_SIZE -> vy = up.
  2. Left paddle hit: vx = left, x <= PADDLE1_X + PADDLE_W, x + BALL_SIZE > PADDLE1_X, and rows overlap (ball_y + BALL_SIZE > p1_y and ball_y < p1_y + PADDLE_H).
     - vx = right; x = PADDLE1_X + PADDLE_W.
     - Right paddle is mirrored: hit when x + BALL_SIZE >= PADDLE2_X; set x = PADDLE2_X - BALL_SIZE.
  3. Miss: x == 0 -> score2++; x == H_ACTIVE - BALL_SIZE -> score1++.
     - Ball recentres; vx points toward the player who conceded; vy unchanged.
     - serve_cnt = SERVE_FRAMES; phase SERVE.
     - If the new score == SCORE_MAX: phase OVER, game_over = 1.
  - A wall bounce and a paddle hit in the same frame both apply.
- OVER:
  - Paddles still move.
  - Leaves on a tick with p1Up and p2Up both set: scores clear, game_over = 0, ball resets as at reset, phase SERVE.
- Scores saturate at SCORE_MAX and never wrap.

## Timing
- Tick sampled at cycle 0. PADDLE at cycle 1, BALL at cycle 2, RESOLVE at cycle 3.
- busy = 1 during cycles 1–3.
- frame_done pulses at cycle 4. All outputs are final from cycle 4 and stay stable until the next tick.
- Outputs may change at cycles 2–4. Total latency is 4 cycles, well inside vertical blanking.
- Reset asserted mid-update: immediate return to reset values; no partial update survives.
- The first tick after reset release is honoured normally.

## Structure
- Package pong_pkg:
  - update-state and phase enums;
  - screen, paddle and ball constants shared with the renderer and VGA timing.
- Sub-module pong_paddle_step: combinational clamped up/down step, instantiated twice.
- All state lives in pong_game_ctrl.

## Test plan
- Reset, then 60 ticks: ball stays at (316,236); the 61st tick gives ball (318,238).
- p1Up held 60 ticks from y = 208: p1_y reaches 0 after 52 ticks and stays 0. p1Up + p1Down together: p1_y unchanged.
- Ball at y = 2, moving up: next update gives y = 0, vy = down; the following update gives y = 2.
- Ball heading left at x = 26, p1_y = 200, ball_y = 230: paddle hit; x = 24, vx = right. Same with p1_y = 0: miss; score2 = 1, ball recentres, SERVE.
- score1 = 8 and right miss: score1 = 9, game_over = 1, ball frozen. Tick with p1Up + p2Up: scores clear, SERVE.
- Ticks at cycles 0 and 2: second tick ignored, one frame_done at cycle 4. rst_n low at cycle 2: reset values at once.
